// File: rtl/aes_regif_pkg.sv
// aes_regif_pkg: address map, register bit positions and FSM states for the AES register interface.
package aes_regif_pkg;
    localparam logic [7:0] ADDR_NAME0   = 8'h00;
    localparam logic [7:0] ADDR_VERSION = 8'h02;
    localparam logic [7:0] ADDR_CTRL    = 8'h08;
    localparam logic [7:0] ADDR_STATUS  = 8'h09;
    localparam logic [7:0] ADDR_CONFIG  = 8'h0a;
    localparam logic [7:0] ADDR_KEY0    = 8'h10;
    localparam logic [7:0] ADDR_KEY7    = 8'h17;
    localparam logic [7:0] ADDR_BLOCK0  = 8'h20;
    localparam logic [7:0] ADDR_BLOCK3  = 8'h23;
    localparam logic [7:0] ADDR_RESULT0 = 8'h30;
    localparam logic [7:0] ADDR_RESULT3 = 8'h33;

    localparam int CTRL_INIT_BIT     = 0;
    localparam int CTRL_NEXT_BIT     = 1;
    localparam int STATUS_READY_BIT  = 0;
    localparam int STATUS_VALID_BIT  = 1;
    localparam int STATUS_ERR_BIT    = 2;
    localparam int CONFIG_ENCDEC_BIT = 0;
    localparam int CONFIG_KEYLEN_BIT = 1;

    typedef enum logic [1:0] {IDLE, ARM, KEY_BUSY, BLK_BUSY} state_e;
endpackage

// File: rtl/aes_regif.sv
// aes_regif: host-bus register bank for the AES core; holds key/block/config, issues init/next
// pulses, tracks command progress and captures the cipher result.
module aes_regif
    import aes_regif_pkg::*;
#(
    parameter logic [31:0] CORE_NAME0   = 32'h61657320,
    parameter logic [31:0] CORE_VERSION = 32'h00000002
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cs,
    input  logic         we,
    input  logic [7:0]   address,
    input  logic [31:0]  write_data,
    output logic [31:0]  read_data,
    output logic         core_init,
    output logic         core_next,
    output logic         core_encdec,
    output logic         core_keylen,
    output logic [255:0] core_key,
    output logic [127:0] core_block,
    input  logic         core_ready,
    input  logic [127:0] core_result,
    input  logic         core_result_valid
);
    state_e       state_q, state_d;
    logic [255:0] key_q, key_d;
    logic [127:0] block_q, block_d;
    logic [127:0] result_q, result_d;
    logic         encdec_q, encdec_d, keylen_q, keylen_d;
    logic         valid_q, valid_d, err_q, err_d;
    logic         init_q, init_d, next_q, next_d;
    logic         req_init_q, req_init_d, req_next_q, req_next_d;
    logic         wr, ctrl_wr, stat_wr, cfg_wr, key_wr, blk_wr;
    logic         idle, pend, go, cmd_init, cmd_next, err_set;

    assign wr       = cs & we;
    assign ctrl_wr  = wr & (address == ADDR_CTRL);
    assign stat_wr  = wr & (address == ADDR_STATUS);
    assign cfg_wr   = wr & (address == ADDR_CONFIG);
    assign key_wr   = wr & (address >= ADDR_KEY0) & (address <= ADDR_KEY7);
    assign blk_wr   = wr & (address >= ADDR_BLOCK0) & (address <= ADDR_BLOCK3);
    assign idle     = state_q == IDLE;
    // A command latched but not yet pulsed blocks a second CTRL write from overwriting it.
    assign pend     = req_init_q | req_next_q;
    assign go       = ctrl_wr & idle & ~pend;
    assign cmd_init = go & write_data[CTRL_INIT_BIT];
    assign cmd_next = go & write_data[CTRL_NEXT_BIT] & ~write_data[CTRL_INIT_BIT];
    assign err_set  = (~idle & (key_wr | blk_wr | cfg_wr | ctrl_wr)) | (ctrl_wr & idle & pend)
                    | (go & write_data[CTRL_INIT_BIT] & write_data[CTRL_NEXT_BIT]);

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        block_d    = block_q;
        result_d   = result_q;
        encdec_d   = encdec_q;
        keylen_d   = keylen_q;
        valid_d    = valid_q;
        init_d     = 1'b0;
        next_d     = 1'b0;
        req_init_d = cmd_init;
        req_next_d = cmd_next;
        for (int i = 0; i < 8; i++)
            if (idle & key_wr & (address[2:0] == i[2:0])) key_d[255-32*i -: 32] = write_data;
        for (int i = 0; i < 4; i++)
            if (idle & blk_wr & (address[1:0] == i[1:0])) block_d[127-32*i -: 32] = write_data;
        if (idle & cfg_wr) begin
            encdec_d = write_data[CONFIG_ENCDEC_BIT];
            keylen_d = write_data[CONFIG_KEYLEN_BIT];
        end
        if (req_next_q) valid_d = 1'b0;
        case (state_q)
            IDLE: if (pend) begin
                state_d = ARM;
                init_d  = req_init_q;
                next_d  = req_next_q;
            end
            ARM: state_d = init_q ? KEY_BUSY : BLK_BUSY;
            KEY_BUSY: if (core_ready) state_d = IDLE;
            BLK_BUSY: begin
                if (core_result_valid) begin
                    result_d = core_result;
                    valid_d  = 1'b1;
                end
                if (core_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        err_d = (err_q & ~(stat_wr & write_data[STATUS_ERR_BIT])) | err_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            key_q      <= '0;
            block_q    <= '0;
            result_q   <= '0;
            encdec_q   <= 1'b0;
            keylen_q   <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            init_q     <= 1'b0;
            next_q     <= 1'b0;
            req_init_q <= 1'b0;
            req_next_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            block_q    <= block_d;
            result_q   <= result_d;
            encdec_q   <= encdec_d;
            keylen_q   <= keylen_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            init_q     <= init_d;
            next_q     <= next_d;
            req_init_q <= req_init_d;
            req_next_q <= req_next_d;
        end
    end

    always_comb begin
        read_data = '0;
        if (cs) begin
            case (address)
                ADDR_NAME0:   read_data = CORE_NAME0;
                ADDR_VERSION: read_data = CORE_VERSION;
                ADDR_STATUS: begin
                    read_data[STATUS_READY_BIT] = idle & core_ready;
                    read_data[STATUS_VALID_BIT] = valid_q;
                    read_data[STATUS_ERR_BIT]   = err_q;
                end
                ADDR_CONFIG: begin
                    read_data[CONFIG_ENCDEC_BIT] = encdec_q;
                    read_data[CONFIG_KEYLEN_BIT] = keylen_q;
                end
                default:
                    if ((address >= ADDR_RESULT0) && (address <= ADDR_RESULT3))
                        read_data = result_q[127-32*int'(address[1:0]) -: 32];
            endcase
        end
    end

    assign core_init   = init_q;
    assign core_next   = next_q;
    assign core_encdec = encdec_q;
    assign core_keylen = keylen_q;
    assign core_key    = key_q;
    assign core_block  = block_q;
endmodule
